uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
Serial-to-parallel UART receiver: 8 data bits, no parity, 1 stop bit, LSB-first on the wire at CLKS_PER_BIT clocks per bit. It is the receive end of the link driven by the team's UART transmitter and sits between the external RX pin and the byte consumer. It synchronises the asynchronous line, validates the start bit at mid-bit, and samples each bit at its centre. It reports each good byte with a one-cycle strobe and flags framing errors.

Parameters:
CLKS_PER_BIT, 6950, system clocks per serial bit; must be ≥ 4. Simulation uses 16.
CNT_W, 13, width of the bit-timing counter; must satisfy 2^CNT_W > CLKS_PER_BIT.

Ports:
i_Clock  input  1  system clock; all logic on the rising edge
i_Reset  input  1  asynchronous, active-high reset
i_Rx_Serial  input  1  raw serial line, asynchronous to i_Clock, idle high
o_Rx_Byte  output  [0:7]  last good byte; index 0 = first data bit received
o_Rx_DV  output  1  one-cycle strobe: o_Rx_Byte just updated with a good frame
o_Rx_Error  output  1  one-cycle strobe: stop bit sampled low (framing error)
o_Rx_Active  output  1  high from validated start bit through stop-bit sample

Behaviour:
- Reset (async assert, sync release): state=IDLE, counter=0, bit index=0, sync flops=1, o_Rx_Byte=0, o_Rx_DV=0, o_Rx_Error=0, o_Rx_Active=0. Reset mid-frame abandons the frame with no strobe.
- Synchroniser: i_Rx_Serial feeds two flops (reset to 1). All FSM decisions use the second flop, r_Rx. Fixed latency is 2 cycles.
- HALF = (CLKS_PER_BIT-1)/2, integer division. Counter counts 0..limit, then clears.
- IDLE: counter=0, index=0. If r_Rx==0, go to START.
- START: count up to HALF. At HALF, re-sample r_Rx:
  - If 0: counter=0, o_Rx_Active=1, go to DATA.
  - If 1: treat as a glitch and return to IDLE. No strobes; o_Rx_Active stays 0.
- DATA: count up to CLKS_PER_BIT-1. At the limit:
  - shift register[index] <= r_Rx, counter=0.
  - If index<7, index++. If index==7, index=0 and go to STOP.
  - Each sample therefore lands one full bit period after the previous one, at bit centre.
- STOP: count up to CLKS_PER_BIT-1. At the limit, sample r_Rx:
  - If 1: o_Rx_Byte <= shift register, o_Rx_DV=1 next cycle, go to CLEANUP.
  - If 0: o_Rx_Error=1 next cycle, o_Rx_Byte unchanged, go to BREAK_WAIT.
  - o_Rx_Active drops to 0 in the same edge either way.
- CLEANUP: one cycle, then IDLE. o_Rx_DV is high during exactly this one cycle.
- BREAK_WAIT: o_Rx_Error high for its first cycle only. Remain until r_Rx==1, then go to IDLE. A stuck-low line or break therefore produces exactly one error, not a stream.
- o_Rx_DV and o_Rx_Error are registered, never high together, and each is high for exactly one cycle per event.
- o_Rx_Byte holds its value between good frames.
- Back-to-back frames with no idle gap must be received. The next start edge lands about HALF cycles after the stop-bit sample, and the FSM is back in IDLE within 2 cycles of that sample.
- Line returning high after START validation is still sampled; only the stop bit is checked.
- Counter never exceeds CLKS_PER_BIT-1. There is no wrap-around of any counter in normal operation.
- Unused state encodings go to IDLE.

Test Plan:
- Reset with line idle high → all outputs 0, no strobes over 20 bit times.
- One frame, CLKS_PER_BIT=16, data bits 1,0,1,0,0,1,0,1 → o_Rx_Byte=10100101 (index 0..7). o_Rx_DV pulses exactly once, 1 cycle wide, about 2 cycles after the stop-bit centre. o_Rx_Error stays 0.
- Line pulsed low for 5 cycles (less than HALF+2) → state returns to IDLE, o_Rx_Active never 1, no strobe. A following valid frame 0xFF (all ones) is then received correctly.
- Frame with stop bit driven 0, then line held low for 3 bit times, then high → single o_Rx_Error pulse, no o_Rx_DV, o_Rx_Byte keeps its prior value. A next frame 00001111 is received with o_Rx_DV.
- Three back-to-back frames with zero idle gap (00000000, 11111111, 01010101) → three o_Rx_DV pulses, bytes in order, no errors.
- i_Reset pulsed during data bit 4 → outputs go to 0 immediately. The partial frame yields no strobe; the next full frame is received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: 8N1, LSB first, CLKS_PER_BIT clocks per bit.
// Two-flop line synchroniser, mid-bit start check, centre sampling.
module uart_rx #(
    parameter int CLKS_PER_BIT = 6950,
    parameter int CNT_W        = 13
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_Rx_Serial,
    output logic [0:7] o_Rx_Byte,
    output logic       o_Rx_DV,
    output logic       o_Rx_Error,
    output logic       o_Rx_Active
);

    localparam int HALF = (CLKS_PER_BIT - 1) / 2;
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        CLEANUP,
        BREAK_WAIT
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       idx;
    logic [0:7]       shreg;
    logic             r_sync;
    logic             r_Rx;

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state       <= IDLE;
            cnt         <= '0;
            idx         <= '0;
            shreg       <= '0;
            r_sync      <= 1'b1;
            r_Rx        <= 1'b1;
            o_Rx_Byte   <= '0;
            o_Rx_DV     <= 1'b0;
            o_Rx_Error  <= 1'b0;
            o_Rx_Active <= 1'b0;
        end else begin
            r_sync     <= i_Rx_Serial;
            r_Rx       <= r_sync;
            o_Rx_DV    <= 1'b0;
            o_Rx_Error <= 1'b0;
            unique case (state)
                IDLE: begin
                    cnt <= '0;
                    idx <= '0;
                    if (!r_Rx) state <= START;
                end
                START: begin
                    if (cnt == CNT_HALF) begin
                        cnt <= '0;
                        if (!r_Rx) begin
                            o_Rx_Active <= 1'b1;
                            state       <= DATA;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == CNT_LAST) begin
                        cnt        <= '0;
                        shreg[idx] <= r_Rx;
                        if (idx == 3'd7) begin
                            idx   <= '0;
                            state <= STOP;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == CNT_LAST) begin
                        cnt         <= '0;
                        o_Rx_Active <= 1'b0;
                        if (r_Rx) begin
                            o_Rx_Byte <= shreg;
                            o_Rx_DV   <= 1'b1;
                            state     <= CLEANUP;
                        end else begin
                            o_Rx_Error <= 1'b1;
                            state      <= BREAK_WAIT;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                CLEANUP: begin
                    state <= IDLE;
                end
                // Hold here until the line recovers so a break flags once
                BREAK_WAIT: begin
                    if (r_Rx) state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames plus random traffic
// compared against a frame-level expectation queue.
module tb_uart_rx;

    localparam int CPB = 16;

    logic       i_Clock = 1'b0;
    logic       i_Reset = 1'b1;
    logic       i_Rx_Serial = 1'b1;
    logic [0:7] o_Rx_Byte;
    logic       o_Rx_DV;
    logic       o_Rx_Error;
    logic       o_Rx_Active;

    uart_rx #(
        .CLKS_PER_BIT(CPB),
        .CNT_W(5)
    ) dut (
        .i_Clock(i_Clock),
        .i_Reset(i_Reset),
        .i_Rx_Serial(i_Rx_Serial),
        .o_Rx_Byte(o_Rx_Byte),
        .o_Rx_DV(o_Rx_DV),
        .o_Rx_Error(o_Rx_Error),
        .o_Rx_Active(o_Rx_Active)
    );

    always #5 i_Clock = ~i_Clock;

    typedef struct {
        bit         err;
        logic [0:7] data;
    } ev_t;

    ev_t        exp_q[$];
    int         n_chk = 0;
    int         n_bad = 0;
    int         n_dv = 0;
    int         n_err = 0;
    int         n_dv_exp = 0;
    int         n_err_exp = 0;
    bit         act_seen = 0;
    logic [0:7] last_good = '0;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    initial begin
        ev_t  e;
        logic pdv;
        logic perr;
        pdv  = 1'b0;
        perr = 1'b0;
        forever begin
            @(negedge i_Clock);
            if (i_Reset) begin
                pdv  = 1'b0;
                perr = 1'b0;
            end else begin
                if (o_Rx_Active) act_seen = 1;
                if (o_Rx_DV || o_Rx_Error) begin
                    chk("dv_err_excl", 32'(o_Rx_DV & o_Rx_Error), 0);
                    chk("strobe_width",
                        32'((o_Rx_DV & pdv) | (o_Rx_Error & perr)), 0);
                    chk("expected_pending", 32'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk("kind", 32'(o_Rx_Error), 32'(e.err));
                        if (!e.err) begin
                            chk("byte", 32'(o_Rx_Byte), 32'(e.data));
                            last_good = e.data;
                        end else begin
                            chk("byte_hold", 32'(o_Rx_Byte), 32'(last_good));
                        end
                    end
                    if (o_Rx_DV) n_dv++;
                    if (o_Rx_Error) n_err++;
                end
                pdv  = o_Rx_DV;
                perr = o_Rx_Error;
            end
        end
    end

    task automatic send_bit(input logic b);
        i_Rx_Serial = b;
        repeat (CPB) @(negedge i_Clock);
    endtask

    task automatic idle_bits(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b1);
    endtask

    task automatic send_frame(input logic [0:7] d, input bit stop_ok);
        ev_t e;
        e.err  = !stop_ok;
        e.data = d;
        exp_q.push_back(e);
        if (stop_ok) n_dv_exp++;
        else n_err_exp++;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            if (i == 4) chk("active_mid", 32'(o_Rx_Active), 1);
            send_bit(d[i]);
        end
        send_bit(stop_ok);
        chk("active_drop", 32'(o_Rx_Active), 0);
    endtask

    task automatic glitch(input int len);
        act_seen    = 0;
        i_Rx_Serial = 1'b0;
        repeat (len) @(negedge i_Clock);
        i_Rx_Serial = 1'b1;
        repeat (2 * CPB) @(negedge i_Clock);
        chk("glitch_active", 32'(act_seen), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [0:7] d;
        int         gap;
        repeat (3) @(negedge i_Clock);
        chk("rst_byte", 32'(o_Rx_Byte), 0);
        chk("rst_active", 32'(o_Rx_Active), 0);
        i_Reset = 1'b0;
        idle_bits(20);
        chk("idle_dv", n_dv, 0);
        chk("idle_err", n_err, 0);
        chk("idle_byte", 32'(o_Rx_Byte), 0);

        send_frame(8'b10100101, 1);
        idle_bits(2);
        chk("first_dv", n_dv, 1);

        glitch(5);
        send_frame(8'b11111111, 1);
        idle_bits(2);

        send_frame(8'b00111100, 0);
        for (int i = 0; i < 3; i++) send_bit(1'b0);
        idle_bits(2);
        chk("break_err", n_err, 1);
        chk("break_hold", 32'(o_Rx_Byte), 32'(8'hFF));
        send_frame(8'b00001111, 1);
        idle_bits(1);

        send_frame(8'b00000000, 1);
        send_frame(8'b11111111, 1);
        send_frame(8'b01010101, 1);
        idle_bits(2);

        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(1)));
        i_Rx_Serial = 1'($urandom_range(1));
        repeat (CPB / 2) @(negedge i_Clock);
        @(posedge i_Clock);
        #2 i_Reset = 1'b1;
        #1;
        chk("arst_byte", 32'(o_Rx_Byte), 0);
        chk("arst_active", 32'(o_Rx_Active), 0);
        chk("arst_dv", 32'(o_Rx_DV), 0);
        chk("arst_err", 32'(o_Rx_Error), 0);
        i_Rx_Serial = 1'b1;
        last_good   = '0;
        repeat (3) @(negedge i_Clock);
        i_Reset = 1'b0;
        idle_bits(3);
        send_frame(8'($urandom), 1);
        idle_bits(1);

        for (int k = 0; k < 12; k++) begin
            d = 8'($urandom);
            if ($urandom_range(3) == 0) glitch(int'($urandom_range(6, 1)));
            if ($urandom_range(4) == 0) begin
                send_frame(d, 0);
                idle_bits(int'($urandom_range(2, 1)));
            end else begin
                send_frame(d, 1);
                gap = int'($urandom_range(2));
                idle_bits(gap);
            end
        end
        idle_bits(3);

        chk("queue_empty", exp_q.size(), 0);
        chk("total_dv", n_dv, n_dv_exp);
        chk("total_err", n_err, n_err_exp);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
